// File: rtl/pwm_engine.sv
// rtl/pwm_engine.sv - 256-tick PWM generator with prescaler, shadowed ratio and drain-on-disable
//
// Purpose:
//   Generates a PWM waveform whose period is 256 ticks, one tick every
//   clk_div+1 clocks.  The requested ratio is staged and only takes effect
//   at a period boundary, so a running period is never shortened or
//   stretched.  Dropping pwm_enable lets the current period finish (DRAIN)
//   before the engine parks in IDLE.
//
// Configuration:
//   PWM_OUT_INVERT_EN - when defined, pwm_signal is inverted everywhere,
//                       including its idle and reset level (which becomes 1).
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   pwm_enable   in   request to generate PWM
//   pwm_ratio    in   [7:0] requested high time, in ticks out of 256
//   pwm_update   in   stages pwm_ratio (strobe or level)
//   clk_div      in   [DIV_WIDTH-1:0] prescale, one tick per clk_div+1 clocks
//   pwm_done     out  one-cycle pulse on the cycle after each period boundary
//   pwm_signal   out  registered PWM waveform
//   active_ratio out  [7:0] ratio currently in effect (shadow register)

module pwm_engine #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pwm_enable,
    input  logic [7:0]           pwm_ratio,
    input  logic                 pwm_update,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 pwm_done,
    output logic                 pwm_signal,
    output logic [7:0]           active_ratio
);

`ifdef PWM_OUT_INVERT_EN
    localparam logic OUT_INVERT = 1'b1;
`else
    localparam logic OUT_INVERT = 1'b0;
`endif

    localparam logic [DIV_WIDTH-1:0] PRE_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] prescaler;
    logic [7:0]           period_cnt;
    logic [7:0]           staging;
    logic                 pending;

    logic                 tick;
    logic                 boundary;

    // ">=" rather than "==": if clk_div is lowered below the current
    // prescaler value the tick still fires on the next clock instead of
    // waiting for the prescaler to wrap.
    always_comb begin
        tick     = 1'b0;
        boundary = 1'b0;
        if (state != ST_IDLE) begin
            tick     = (prescaler >= clk_div);
            boundary = tick && (period_cnt == 8'hFF);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            prescaler    <= '0;
            period_cnt   <= 8'h00;
            staging      <= 8'h00;
            pending      <= 1'b0;
            active_ratio <= 8'h00;
            pwm_done     <= 1'b0;
            pwm_signal   <= OUT_INVERT;
        end else begin
            // Output uses the pre-edge counter and ratio: one cycle of latency.
            pwm_signal <= OUT_INVERT ^ ((state != ST_IDLE) && (period_cnt < active_ratio));
            pwm_done   <= boundary;

            case (state)
                ST_IDLE: begin
                    prescaler  <= '0;
                    period_cnt <= 8'h00;
                    pending    <= 1'b0;
                    if (pwm_enable) begin
                        // Load the ratio directly so the very first period is correct.
                        state        <= ST_RUN;
                        active_ratio <= pwm_ratio;
                    end
                end

                default: begin
                    if (tick) begin
                        prescaler  <= '0;
                        period_cnt <= period_cnt + 8'd1;
                    end else begin
                        prescaler  <= prescaler + PRE_ONE;
                    end

                    // An update landing exactly on the boundary bypasses
                    // staging so the newest value is never lost.
                    if (pwm_update) begin
                        if (boundary) begin
                            active_ratio <= pwm_ratio;
                            pending      <= 1'b0;
                        end else begin
                            staging      <= pwm_ratio;
                            pending      <= 1'b1;
                        end
                    end else if (boundary && pending) begin
                        active_ratio <= staging;
                        pending      <= 1'b0;
                    end

                    if (state == ST_DRAIN) begin
                        if (pwm_enable) begin
                            state <= ST_RUN;
                        end else if (boundary) begin
                            state <= ST_IDLE;
                        end
                    end else if (!pwm_enable) begin
                        state <= boundary ? ST_IDLE : ST_DRAIN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_engine.sv
// tb/tb_pwm_engine.sv - self-checking bench for pwm_engine

module tb_pwm_engine;

`ifdef PWM_OUT_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       pwm_enable;
    logic [7:0] pwm_ratio;
    logic       pwm_update;
    logic [7:0] clk_div;
    logic       pwm_done;
    logic       pwm_signal;
    logic [7:0] active_ratio;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_engine #(.DIV_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .pwm_enable   (pwm_enable),
        .pwm_ratio    (pwm_ratio),
        .pwm_update   (pwm_update),
        .clk_div      (clk_div),
        .pwm_done     (pwm_done),
        .pwm_signal   (pwm_signal),
        .active_ratio (active_ratio)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: engine is "on" or off; when on it counts clocks into
    // ticks and ticks into a 256-tick period.
    bit m_on, m_drain;
    int m_pre, m_cnt, m_stage, m_pend, m_act, m_sig, m_done;

    task automatic model_edge();
        bit tk, last;
        if (reset) begin
            m_on = 0; m_drain = 0; m_pre = 0; m_cnt = 0; m_stage = 0;
            m_pend = 0; m_act = 0; m_sig = 0; m_done = 0;
        end else if (!m_on) begin
            m_sig = 0; m_done = 0; m_pre = 0; m_cnt = 0; m_pend = 0;
            if (pwm_enable) begin
                m_on = 1; m_drain = 0; m_act = int'(pwm_ratio);
            end
        end else begin
            tk   = (m_pre >= int'(clk_div));
            last = tk && (m_cnt == 255);
            m_sig  = (m_cnt < m_act) ? 1 : 0;
            m_done = last ? 1 : 0;
            if (pwm_update) begin
                if (last) begin m_act = int'(pwm_ratio); m_pend = 0; end
                else begin m_stage = int'(pwm_ratio); m_pend = 1; end
            end else if (last && m_pend == 1) begin
                m_act = m_stage; m_pend = 0;
            end
            if (tk) begin m_pre = 0; m_cnt = (m_cnt + 1) % 256; end
            else m_pre = m_pre + 1;
            if (m_drain) begin
                if (pwm_enable) m_drain = 0;
                else if (last) begin m_on = 0; m_drain = 0; end
            end else if (!pwm_enable) begin
                if (last) m_on = 0;
                else m_drain = 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic restart(input int div, input int ratio);
        reset = 1; pwm_enable = 0; pwm_update = 0;
        clk_div = 8'(div); pwm_ratio = 8'(ratio);
        step();
        reset = 0; pwm_enable = 1;
        step();
    endtask

    task automatic wait_cnt(input int target, input string tag);
        int k = 0;
        while (m_cnt != target && k < 2000) begin step(); k++; end
        if (k >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for period_cnt=%0d", tag, target);
        end
    endtask

    task automatic test_reset();
        reset = 1; pwm_enable = 1; pwm_update = 1; pwm_ratio = 8'h55; clk_div = 8'd0;
        repeat (3) step();
        n_cmp++;
        if (pwm_signal !== INV) begin n_bad++; $display("FAIL reset_sig: got %b want %b", pwm_signal, INV); end
        n_cmp++;
        if (pwm_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", pwm_done); end
        n_cmp++;
        if (active_ratio !== 8'h00) begin n_bad++; $display("FAIL reset_ratio: got %h want 00", active_ratio); end
    endtask

    task automatic test_basic();
        int hi, dn;
        restart(0, 'h40);
        pwm_update = 1;
        for (int w = 0; w < 2; w++) begin
            hi = 0; dn = 0;
            repeat (256) begin
                step();
                hi += int'(pwm_signal ^ INV);
                dn += int'(pwm_done);
            end
            n_cmp++;
            if (hi != 64) begin n_bad++; $display("FAIL basic_high[%0d]: got %0d want 64", w, hi); end
            n_cmp++;
            if (dn != 1) begin n_bad++; $display("FAIL basic_done[%0d]: got %0d want 1", w, dn); end
        end
        pwm_update = 0;
        n_cmp++;
        if (active_ratio !== 8'h40) begin n_bad++; $display("FAIL basic_ratio: got %h want 40", active_ratio); end
    endtask

    task automatic test_update();
        int hi;
        wait_cnt(0, "update_align");
        pwm_ratio = 8'h80;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            pwm_update = (m_cnt == 'h10);
            step();
            hi += int'(pwm_signal ^ INV);
            if (i == 200) begin
                n_cmp++;
                if (active_ratio !== 8'h40) begin n_bad++; $display("FAIL update_mid: got %h want 40", active_ratio); end
            end
        end
        pwm_update = 0;
        n_cmp++;
        if (hi != 64) begin n_bad++; $display("FAIL update_cur_high: got %0d want 64", hi); end
        n_cmp++;
        if (active_ratio !== 8'h80) begin n_bad++; $display("FAIL update_boundary: got %h want 80", active_ratio); end
        hi = 0;
        repeat (256) begin step(); hi += int'(pwm_signal ^ INV); end
        n_cmp++;
        if (hi != 128) begin n_bad++; $display("FAIL update_next_high: got %0d want 128", hi); end
    endtask

    task automatic test_extremes();
        int hi;
        restart(0, 'h00);
        hi = 0;
        repeat (300) begin step(); hi += int'(pwm_signal ^ INV); end
        n_cmp++;
        if (hi != 0) begin n_bad++; $display("FAIL ratio00_high: got %0d want 0", hi); end
        pwm_ratio = 8'hFF; pwm_update = 1;
        step();
        pwm_update = 0;
        wait_cnt(0, "ratioFF_align");
        hi = 0;
        repeat (256) begin step(); hi += int'(pwm_signal ^ INV); end
        n_cmp++;
        if (hi != 255) begin n_bad++; $display("FAIL ratioFF_high: got %0d want 255", hi); end
        n_cmp++;
        if (active_ratio !== 8'hFF) begin n_bad++; $display("FAIL ratioFF_active: got %h want ff", active_ratio); end
    endtask

    task automatic test_prescale();
        int hi, dn, k, bad;
        restart(3, 'h80);
        hi = 0; dn = 0;
        repeat (1024) begin
            step();
            hi += int'(pwm_signal ^ INV);
            dn += int'(pwm_done);
        end
        n_cmp++;
        if (hi != 512) begin n_bad++; $display("FAIL div3_high: got %0d want 512", hi); end
        n_cmp++;
        if (dn != 1) begin n_bad++; $display("FAIL div3_done: got %0d want 1", dn); end
        k = 0;
        while (m_pre != 2 && k < 20) begin step(); k++; end
        n_cmp++;
        if (k >= 20) begin n_bad++; $display("FAIL div_drop_align: timeout waiting for prescaler=2"); end
        clk_div = 8'd0;
        bad = 0; dn = 0;
        repeat (600) begin
            step();
            dn += int'(pwm_done);
            if (pwm_signal !== (1'(m_sig) ^ INV) || pwm_done !== 1'(m_done)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL div_drop_track: %0d cycles differ from model, want 0", bad); end
        n_cmp++;
        if (dn < 2) begin n_bad++; $display("FAIL div_drop_lockup: got %0d done pulses want >=2", dn); end
    endtask

    task automatic test_drain();
        int k, dn, hi;
        restart(0, 'h40);
        wait_cnt('h20, "drain_align");
        pwm_enable = 0;
        k = 0; dn = 0;
        while (m_on && k < 400) begin step(); k++; dn += int'(pwm_done); end
        n_cmp++;
        if (k != 224) begin n_bad++; $display("FAIL drain_len: got %0d clocks want 224", k); end
        n_cmp++;
        if (dn != 1) begin n_bad++; $display("FAIL drain_done: got %0d want 1", dn); end
        dn = 0; hi = 0;
        repeat (300) begin step(); dn += int'(pwm_done); hi += int'(pwm_signal ^ INV); end
        n_cmp++;
        if (dn != 0 || hi != 0) begin n_bad++; $display("FAIL idle_quiet: got done=%0d high=%0d want 0/0", dn, hi); end
        pwm_enable = 1;
        step();
        wait_cnt('h20, "reenable_align");
        pwm_enable = 0;
        repeat (10) step();
        pwm_enable = 1;
        dn = 0; hi = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            dn += int'(pwm_done);
            if (i >= 300 && i < 556) hi += int'(pwm_signal ^ INV);
        end
        n_cmp++;
        if (dn != 2) begin n_bad++; $display("FAIL reenable_done: got %0d want 2", dn); end
        n_cmp++;
        if (hi != 64) begin n_bad++; $display("FAIL reenable_high: got %0d want 64", hi); end
    endtask

    task automatic test_reset_mid();
        int dn;
        restart(0, 'h80);
        wait_cnt('h30, "rst_align");
        n_cmp++;
        if (pwm_signal !== ~INV) begin n_bad++; $display("FAIL rst_pre_high: got %b want %b", pwm_signal, ~INV); end
        reset = 1; pwm_enable = 0;
        step();
        reset = 0;
        n_cmp++;
        if (pwm_signal !== INV) begin n_bad++; $display("FAIL rst_sig: got %b want %b", pwm_signal, INV); end
        n_cmp++;
        if (active_ratio !== 8'h00) begin n_bad++; $display("FAIL rst_ratio: got %h want 00", active_ratio); end
        dn = int'(pwm_done);
        repeat (300) begin step(); dn += int'(pwm_done); end
        n_cmp++;
        if (dn != 0) begin n_bad++; $display("FAIL rst_done: got %0d want 0", dn); end
    endtask

    task automatic test_random();
        restart(1, $urandom_range(0, 255));
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) pwm_enable = ~pwm_enable;
            if ($urandom_range(0, 399) == 0) clk_div = 8'($urandom_range(0, 2));
            reset      = ($urandom_range(0, 999) == 0);
            pwm_update = ($urandom_range(0, 39) == 0);
            pwm_ratio  = 8'($urandom);
            step();
            n_cmp++;
            if (pwm_signal !== (1'(m_sig) ^ INV)) begin n_bad++; $display("FAIL rnd_sig @%0d: got %b want %b", i, pwm_signal, 1'(m_sig) ^ INV); end
            n_cmp++;
            if (pwm_done !== 1'(m_done)) begin n_bad++; $display("FAIL rnd_done @%0d: got %b want %b", i, pwm_done, 1'(m_done)); end
            n_cmp++;
            if (active_ratio !== 8'(m_act)) begin n_bad++; $display("FAIL rnd_ratio @%0d: got %h want %h", i, active_ratio, 8'(m_act)); end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; pwm_enable = 0; pwm_ratio = 8'h00; pwm_update = 0; clk_div = 8'd0;
        test_reset();
        test_basic();
        test_update();
        test_extremes();
        test_prescale();
        test_drain();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_engine.md
PWM_ENGINE -- requirements
Module: pwm_engine

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, the width of the clk_div prescale input.
REQ-002 SHALL have port clock  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pwm_enable  input  1  request to generate PWM.
REQ-005 SHALL have port pwm_ratio  input  8  requested high time, in ticks out of 256.
REQ-006 SHALL have port pwm_update  input  1  strobe or level that stages pwm_ratio.
REQ-007 SHALL have port clk_div  input  DIV_WIDTH  prescale value; one tick occurs every clk_div+1 clocks.
REQ-008 SHALL have port pwm_done  output  1  one-cycle pulse at each period end.
REQ-009 SHALL have port pwm_signal  output  1  registered PWM waveform.
REQ-010 SHALL have port active_ratio  output  8  ratio currently in effect (the shadow register).

Function
REQ-011 SHALL implement the states IDLE, RUN and DRAIN.
REQ-012 SHALL hold the prescaler, period_cnt and pending at 0 while in IDLE.
REQ-013 SHALL, in IDLE with pwm_enable=1, go to RUN next cycle and load active_ratio from pwm_ratio, so the first period is correct.
REQ-014 SHALL, in RUN/DRAIN, increment the prescaler each clock and tick when prescaler >= clk_div (>= so that lowering clk_div cannot cause lockup); on a tick the prescaler clears to 0.
REQ-015 SHALL increment the 8-bit period_cnt on every tick and wrap 255->0; a period is 256 ticks.
REQ-016 SHALL define the period boundary as a tick with period_cnt==255.
REQ-017 SHALL, on pwm_update=1 in RUN/DRAIN, capture pwm_ratio into a staging register and set pending.
REQ-018 SHALL, at a period boundary with pending=1, copy staging into active_ratio and clear pending.
REQ-019 SHALL, when pwm_update=1 occurs in the boundary cycle itself, load pwm_ratio directly into active_ratio and clear pending; the newest value wins.
REQ-020 SHALL never change active_ratio mid-period (no runt or stretched pulses).
REQ-021 SHALL register pwm_signal as (state!=IDLE && period_cnt < active_ratio), giving one cycle of latency.
REQ-022 SHALL produce a constant-low output for ratio 0x00, and high for 255 of 256 ticks for ratio 0xFF.
REQ-023 SHALL register pwm_done so that it is high for exactly one clock, on the cycle after each period boundary, in RUN and in DRAIN.
REQ-024 SHALL, in RUN with pwm_enable=0, go to DRAIN; counting continues to complete the current period.
REQ-025 SHALL, in DRAIN with pwm_enable=1, return to RUN with no counter disturbance.
REQ-026 SHALL, in DRAIN at a period boundary, go to IDLE; pwm_done still pulses, and pwm_signal is low from the next cycle.
REQ-027 SHALL, when the enable fall and the period boundary occur in the same cycle in RUN, go directly to IDLE.
REQ-028 SHALL ignore pwm_update in IDLE.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set state=IDLE and clear the prescaler, period_cnt, staging, pending and active_ratio to 0.
REQ-030 SHALL, on reset, drive pwm_signal=0 (subject to REQ-033) and pwm_done=0.
REQ-031 SHALL let reset take priority over every other input, including mid-period; the output goes to its idle level on the next cycle with no pwm_done pulse.

Configuration
REQ-032 SHALL use the macro PWM_OUT_INVERT_EN to select output polarity.
REQ-033 SHALL, with PWM_OUT_INVERT_EN defined, invert pwm_signal everywhere, including idle and reset, where it drives 1.
REQ-034 SHALL, without PWM_OUT_INVERT_EN, produce active-high output with an idle level of 0; all other behaviour is unchanged.

Verification
REQ-035 SHALL cover: clk_div=0, ratio=0x40, update=1, enable=1 -> pwm_signal high 64 of every 256 clocks and pwm_done every 256 clocks.
REQ-036 SHALL cover: running ratio 0x40, update pulse with 0x80 at period_cnt=0x10 -> current period has 64 ticks high, next period 128, and active_ratio changes on the boundary.
REQ-037 SHALL cover: ratio 0x00, then 0xFF -> pwm_signal never high, then high 255 of 256 ticks.
REQ-038 SHALL cover: clk_div=3, ratio=0x80 -> period 1024 clocks with 512 clocks high; clk_div dropped to 0 while prescaler=2 -> tick on the next clock with no lockup.
REQ-039 SHALL cover: enable dropped at period_cnt=0x20 -> period completes to 255, one pwm_done, then IDLE; re-enable during DRAIN -> stays in RUN.
REQ-040 SHALL cover: reset asserted at period_cnt=0x30 while high -> next cycle pwm_signal=0, active_ratio=0, state IDLE, no pwm_done.
